// File: rtl/instr_decode.sv
// MIPS32 instruction-decode stage: field split, control generation, immediate
// extension and a 32x32 register file, all registered into the ID/EX boundary.
module instr_decode (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic [4:0]  rs_addr,
    output logic [4:0]  rt_addr,
    output logic [4:0]  dest_addr,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    output logic [31:0] imm_ext,
    output logic [4:0]  shamt,
    output logic [3:0]  alu_op,
    output logic        alu_src,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        branch_eq,
    output logic        branch_ne,
    output logic        jump,
    output logic [25:0] jump_target,
    output logic        illegal
);

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_NOR = 4'd5;
    localparam logic [3:0] ALU_SLT = 4'd6;
    localparam logic [3:0] ALU_SLL = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8;
    localparam logic [3:0] ALU_LUI = 4'd9;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] dest_raw;
    logic       itype;
    logic       zero_ext;

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    logic [4:0]  rs_addr_q, rt_addr_q, dest_addr_q, shamt_q;
    logic [4:0]  dest_addr_d;
    logic [31:0] rs_data_q, rt_data_q, imm_ext_q;
    logic [31:0] rs_data_d, rt_data_d, imm_ext_d;
    logic [3:0]  alu_op_q, alu_op_d;
    logic        alu_src_q, alu_src_d, reg_write_q, reg_write_d;
    logic        mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic        mem_to_reg_q, mem_to_reg_d;
    logic        branch_eq_q, branch_eq_d, branch_ne_q, branch_ne_d;
    logic        jump_q, jump_d, illegal_q, illegal_d;
    logic [25:0] jump_target_q;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];

    always_comb begin
        alu_op_d     = ALU_ADD;
        alu_src_d    = 1'b0;
        reg_write_d  = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        branch_eq_d  = 1'b0;
        branch_ne_d  = 1'b0;
        jump_d       = 1'b0;
        illegal_d    = 1'b0;
        dest_raw     = 5'd0;
        itype        = 1'b0;
        zero_ext     = 1'b0;
        case (opcode)
            6'h00: begin
                reg_write_d = 1'b1;
                dest_raw    = instr[15:11];
                case (funct)
                    6'h20, 6'h21: alu_op_d = ALU_ADD;
                    6'h22, 6'h23: alu_op_d = ALU_SUB;
                    6'h24:        alu_op_d = ALU_AND;
                    6'h25:        alu_op_d = ALU_OR;
                    6'h26:        alu_op_d = ALU_XOR;
                    6'h27:        alu_op_d = ALU_NOR;
                    6'h2A:        alu_op_d = ALU_SLT;
                    6'h00:        alu_op_d = ALU_SLL;
                    6'h02:        alu_op_d = ALU_SRL;
                    default: begin
                        illegal_d   = 1'b1;
                        reg_write_d = 1'b0;
                    end
                endcase
            end
            6'h08, 6'h09: itype = 1'b1;
            6'h0A: begin itype = 1'b1; alu_op_d = ALU_SLT; end
            6'h0C: begin itype = 1'b1; alu_op_d = ALU_AND; zero_ext = 1'b1; end
            6'h0D: begin itype = 1'b1; alu_op_d = ALU_OR;  zero_ext = 1'b1; end
            6'h0E: begin itype = 1'b1; alu_op_d = ALU_XOR; zero_ext = 1'b1; end
            6'h0F: begin itype = 1'b1; alu_op_d = ALU_LUI; end
            6'h23: begin
                alu_src_d    = 1'b1;
                mem_read_d   = 1'b1;
                mem_to_reg_d = 1'b1;
                reg_write_d  = 1'b1;
                dest_raw     = instr[20:16];
            end
            6'h2B: begin
                alu_src_d   = 1'b1;
                mem_write_d = 1'b1;
            end
            6'h04: begin alu_op_d = ALU_SUB; branch_eq_d = 1'b1; end
            6'h05: begin alu_op_d = ALU_SUB; branch_ne_d = 1'b1; end
            6'h02: jump_d = 1'b1;
            default: illegal_d = 1'b1;
        endcase
        if (itype) begin
            alu_src_d   = 1'b1;
            reg_write_d = 1'b1;
            dest_raw    = instr[20:16];
        end
        // A non-writing instruction must never present a live destination to hazard logic.
        dest_addr_d = reg_write_d ? dest_raw : 5'd0;
        imm_ext_d   = zero_ext ? {16'h0000, instr[15:0]} : {{16{instr[15]}}, instr[15:0]};
    end

    // Write-back lands this edge, so a matching read takes wb_data directly.
    always_comb begin
        regs_d = regs_q;
        if (wb_we && (wb_addr != 5'd0)) begin
            regs_d[wb_addr] = wb_data;
        end
        regs_d[0] = 32'd0;
        rs_data_d = (wb_we && (wb_addr != 5'd0) && (wb_addr == instr[25:21])) ? wb_data
                                                                               : regs_q[instr[25:21]];
        rt_data_d = (wb_we && (wb_addr != 5'd0) && (wb_addr == instr[20:16])) ? wb_data
                                                                               : regs_q[instr[20:16]];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rs_addr_q     <= 5'd0;
            rt_addr_q     <= 5'd0;
            dest_addr_q   <= 5'd0;
            shamt_q       <= 5'd0;
            rs_data_q     <= 32'd0;
            rt_data_q     <= 32'd0;
            imm_ext_q     <= 32'd0;
            alu_op_q      <= ALU_ADD;
            alu_src_q     <= 1'b0;
            reg_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_to_reg_q  <= 1'b0;
            branch_eq_q   <= 1'b0;
            branch_ne_q   <= 1'b0;
            jump_q        <= 1'b0;
            jump_target_q <= 26'd0;
            illegal_q     <= 1'b0;
        end else begin
            rs_addr_q     <= instr[25:21];
            rt_addr_q     <= instr[20:16];
            dest_addr_q   <= dest_addr_d;
            shamt_q       <= instr[10:6];
            rs_data_q     <= rs_data_d;
            rt_data_q     <= rt_data_d;
            imm_ext_q     <= imm_ext_d;
            alu_op_q      <= alu_op_d;
            alu_src_q     <= alu_src_d;
            reg_write_q   <= reg_write_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_to_reg_q  <= mem_to_reg_d;
            branch_eq_q   <= branch_eq_d;
            branch_ne_q   <= branch_ne_d;
            jump_q        <= jump_d;
            jump_target_q <= instr[25:0];
            illegal_q     <= illegal_d;
        end
    end

    assign rs_addr     = rs_addr_q;
    assign rt_addr     = rt_addr_q;
    assign dest_addr   = dest_addr_q;
    assign shamt       = shamt_q;
    assign rs_data     = rs_data_q;
    assign rt_data     = rt_data_q;
    assign imm_ext     = imm_ext_q;
    assign alu_op      = alu_op_q;
    assign alu_src     = alu_src_q;
    assign reg_write   = reg_write_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_to_reg  = mem_to_reg_q;
    assign branch_eq   = branch_eq_q;
    assign branch_ne   = branch_ne_q;
    assign jump        = jump_q;
    assign jump_target = jump_target_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_instr_decode.sv
// Bench for instr_decode: directed decode vectors, bypass and reset cases, then
// randomized back-to-back instructions against a table-driven reference model.
module tb_instr_decode;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instr = 32'd0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_addr = 5'd0;
    logic [31:0] wb_data = 32'd0;

    logic [4:0]  rs_addr, rt_addr, dest_addr, shamt;
    logic [31:0] rs_data, rt_data, imm_ext;
    logic [3:0]  alu_op;
    logic        alu_src, reg_write, mem_read, mem_write, mem_to_reg;
    logic        branch_eq, branch_ne, jump, illegal;
    logic [25:0] jump_target;

    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  shamt;
        logic [3:0]  alu_op;
        logic        alu_src;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        beq;
        logic        bne;
        logic        jump;
        logic [25:0] jt;
        logic        illegal;
    } obs_t;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mregs [32];
    logic [3:0]  r_alu [logic [5:0]];
    logic [3:0]  i_alu [logic [5:0]];

    instr_decode dut (
        .clk(clk), .rst(rst), .instr(instr), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .dest_addr(dest_addr), .rs_data(rs_data),
        .rt_data(rt_data), .imm_ext(imm_ext), .shamt(shamt), .alu_op(alu_op), .alu_src(alu_src),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .branch_eq(branch_eq), .branch_ne(branch_ne), .jump(jump), .jump_target(jump_target),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic obs_t dut_obs();
        obs_t o;
        o = '{rs_addr, rt_addr, dest_addr, rs_data, rt_data, imm_ext, shamt, alu_op, alu_src,
              reg_write, mem_read, mem_write, mem_to_reg, branch_eq, branch_ne, jump,
              jump_target, illegal};
        return o;
    endfunction

    function automatic obs_t model(input logic [31:0] ins, input logic we,
                                   input logic [4:0] wa, input logic [31:0] wd);
        obs_t e;
        logic [5:0] op;
        logic [5:0] fn;
        op = ins[31:26];
        fn = ins[5:0];
        e = '0;
        e.rs = ins[25:21];
        e.rt = ins[20:16];
        e.shamt = ins[10:6];
        e.jt = ins[25:0];
        e.rs_data = (we && wa != 0 && wa == e.rs) ? wd : mregs[e.rs];
        e.rt_data = (we && wa != 0 && wa == e.rt) ? wd : mregs[e.rt];
        if (op == 6'h0C || op == 6'h0D || op == 6'h0E) e.imm = {16'h0, ins[15:0]};
        else e.imm = {{16{ins[15]}}, ins[15:0]};
        if (op == 6'h00) begin
            if (r_alu.exists(fn)) begin
                e.alu_op = r_alu[fn];
                e.reg_write = 1'b1;
                e.dest = ins[15:11];
            end else begin
                e.illegal = 1'b1;
            end
        end else if (i_alu.exists(op)) begin
            e.alu_op = i_alu[op];
            e.alu_src = 1'b1;
            e.reg_write = 1'b1;
            e.dest = e.rt;
        end else if (op == 6'h23) begin
            e.alu_src = 1'b1; e.mem_read = 1'b1; e.mem_to_reg = 1'b1; e.reg_write = 1'b1;
            e.dest = e.rt;
        end else if (op == 6'h2B) begin
            e.alu_src = 1'b1; e.mem_write = 1'b1;
        end else if (op == 6'h04) begin
            e.alu_op = 4'd1; e.beq = 1'b1;
        end else if (op == 6'h05) begin
            e.alu_op = 4'd1; e.bne = 1'b1;
        end else if (op == 6'h02) begin
            e.jump = 1'b1;
        end else begin
            e.illegal = 1'b1;
        end
        return e;
    endfunction

    task automatic step(input logic [31:0] ins, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, output obs_t exp);
        exp = model(ins, we, wa, wd);
        instr = ins; wb_we = we; wb_addr = wa; wb_data = wd;
        @(posedge clk);
        #1;
        if (we && wa != 0) mregs[wa] = wd;
        wb_we = 1'b0;
    endtask

    task automatic test_reset();
        obs_t got, exp;
        instr = 32'hFC00_0000;
        @(posedge clk); #1;
        got = dut_obs(); n_cmp++;
        if (got !== '0) begin n_bad++; $display("FAIL reset_outputs got=%h exp=0", got); end
        rst = 1'b1;
        step(32'h0043_1020, 1'b0, 5'd0, 32'd0, exp);
        got = dut_obs(); n_cmp++;
        if (got.rs_data !== 32'd0 || got.rt_data !== 32'd0) begin
            n_bad++; $display("FAIL reset_regs_zero got=%h/%h exp=0/0", got.rs_data, got.rt_data);
        end
    endtask

    task automatic test_alu_fields();
        obs_t got, exp;
        logic [31:0] vec [4] = '{32'h0043_1020, 32'h0043_1024, 32'h0043_1022, 32'h0043_1025};
        logic [3:0]  aop [4] = '{4'd0, 4'd2, 4'd1, 4'd3};
        step(32'd0, 1'b1, 5'd2, 32'd5, exp);
        step(32'd0, 1'b1, 5'd3, 32'd7, exp);
        for (int i = 0; i < 4; i++) begin
            step(vec[i], 1'b0, 5'd0, 32'd0, exp);
            got = dut_obs(); n_cmp++;
            if (got.rs !== 5'd2 || got.rt !== 5'd3 || got.dest !== 5'd2 || got.rs_data !== 32'd5 ||
                got.rt_data !== 32'd7 || got.alu_op !== aop[i] || got.alu_src !== 1'b0 ||
                got.reg_write !== 1'b1) begin
                n_bad++; $display("FAIL rtype_%0d got=%h", i, got);
            end
            n_cmp++;
            if (got !== exp) begin n_bad++; $display("FAIL rtype_model_%0d got=%h exp=%h", i, got, exp); end
        end
    endtask

    task automatic test_immediates();
        obs_t got, exp;
        step(32'h2042_0002, 1'b0, 5'd0, 32'd0, exp);
        got = dut_obs(); n_cmp++;
        if (got.dest !== 5'd2 || got.imm !== 32'd2 || got.alu_src !== 1'b1 || got.reg_write !== 1'b1) begin
            n_bad++; $display("FAIL addi_pos got=%h", got);
        end
        step(32'h2042_FFFE, 1'b0, 5'd0, 32'd0, exp);
        got = dut_obs(); n_cmp++;
        if (got.imm !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL addi_neg got=%h exp=fffffffe", got.imm); end
        step(32'h3442_8001, 1'b0, 5'd0, 32'd0, exp);
        got = dut_obs(); n_cmp++;
        if (got.imm !== 32'h0000_8001 || got.alu_op !== 4'd3) begin
            n_bad++; $display("FAIL ori_zext got=%h/%0d exp=00008001/3", got.imm, got.alu_op);
        end
        step(32'h3C02_8000, 1'b0, 5'd0, 32'd0, exp);
        got = dut_obs(); n_cmp++;
        if (got.imm !== 32'hFFFF_8000 || got.alu_op !== 4'd9) begin
            n_bad++; $display("FAIL lui_sext got=%h/%0d exp=ffff8000/9", got.imm, got.alu_op);
        end
    endtask

    task automatic test_bypass();
        obs_t got, exp;
        step(32'h0043_1020, 1'b1, 5'd2, 32'd9, exp);
        got = dut_obs(); n_cmp++;
        if (got.rs_data !== 32'd9 || got.rt_data !== 32'd7) begin
            n_bad++; $display("FAIL bypass_rs got=%h/%h exp=9/7", got.rs_data, got.rt_data);
        end
        step(32'h0003_1020, 1'b1, 5'd0, 32'hDEAD_BEEF, exp);
        got = dut_obs(); n_cmp++;
        if (got.rs_data !== 32'd0) begin n_bad++; $display("FAIL zero_bypass got=%h exp=0", got.rs_data); end
        step(32'h0003_1020, 1'b0, 5'd0, 32'd0, exp);
        got = dut_obs(); n_cmp++;
        if (got.rs_data !== 32'd0) begin n_bad++; $display("FAIL zero_write got=%h exp=0", got.rs_data); end
    endtask

    task automatic test_load_illegal();
        obs_t got, exp;
        step(32'hFC00_0000, 1'b0, 5'd0, 32'd0, exp);
        got = dut_obs(); n_cmp++;
        if (got.illegal !== 1'b1 || got.reg_write !== 1'b0 || got.mem_write !== 1'b0 || got.dest !== 5'd0) begin
            n_bad++; $display("FAIL illegal_op got=%h", got);
        end
        step(32'h8C43_0004, 1'b0, 5'd0, 32'd0, exp);
        got = dut_obs(); n_cmp++;
        if (got.mem_read !== 1'b1 || got.imm !== 32'd4 || got.mem_to_reg !== 1'b1 || got.dest !== 5'd3) begin
            n_bad++; $display("FAIL lw got=%h", got);
        end
        step(32'h0043_103F, 1'b0, 5'd0, 32'd0, exp);
        got = dut_obs(); n_cmp++;
        if (got !== exp || got.illegal !== 1'b1) begin
            n_bad++; $display("FAIL illegal_funct got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_reset_midstream();
        obs_t got, exp;
        step(32'h0043_1020, 1'b0, 5'd0, 32'd0, exp);
        #2;
        rst = 1'b0;
        #1;
        got = dut_obs(); n_cmp++;
        if (got !== '0) begin n_bad++; $display("FAIL reset_async got=%h exp=0", got); end
        instr = 32'h8C43_0004;
        @(posedge clk); #1;
        got = dut_obs(); n_cmp++;
        if (got !== '0) begin n_bad++; $display("FAIL reset_hold got=%h exp=0", got); end
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        rst = 1'b1;
        step(32'h0043_1020, 1'b0, 5'd0, 32'd0, exp);
        got = dut_obs(); n_cmp++;
        if (got !== exp || got.rs_data !== 32'd0) begin
            n_bad++; $display("FAIL reset_regs_cleared got=%h exp=%h", got, exp);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops [13] = '{6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                                 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
        logic [5:0] fns [11] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                 6'h2A, 6'h00, 6'h02};
        logic [31:0] r;
        int k;
        r = $urandom;
        k = $urandom_range(0, 14);
        if (k < 13) r[31:26] = ops[k];
        if (r[31:26] == 6'h00 && $urandom_range(0, 7) != 0) r[5:0] = fns[$urandom_range(0, 10)];
        if ($urandom_range(0, 1) == 1) begin
            r[25:21] = 5'($urandom_range(0, 7));
            r[20:16] = 5'($urandom_range(0, 7));
        end
        return r;
    endfunction

    task automatic test_random();
        obs_t got, exp;
        for (int i = 0; i < 400; i++) begin
            step(rand_instr(), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom, exp);
            got = dut_obs(); n_cmp++;
            if (got !== exp) begin n_bad++; $display("FAIL random_%0d got=%h exp=%h", i, got, exp); end
        end
    endtask

    initial begin
        r_alu[6'h20] = 4'd0; r_alu[6'h21] = 4'd0; r_alu[6'h22] = 4'd1; r_alu[6'h23] = 4'd1;
        r_alu[6'h24] = 4'd2; r_alu[6'h25] = 4'd3; r_alu[6'h26] = 4'd4; r_alu[6'h27] = 4'd5;
        r_alu[6'h2A] = 4'd6; r_alu[6'h00] = 4'd7; r_alu[6'h02] = 4'd8;
        i_alu[6'h08] = 4'd0; i_alu[6'h09] = 4'd0; i_alu[6'h0A] = 4'd6; i_alu[6'h0C] = 4'd2;
        i_alu[6'h0D] = 4'd3; i_alu[6'h0E] = 4'd4; i_alu[6'h0F] = 4'd9;
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        #1;
        test_reset();
        test_alu_fields();
        test_immediates();
        test_bypass();
        test_load_illegal();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
